// File: rtl/btn_event_ctrl.sv
// ============================================================================
//  Module      : btn_event_ctrl
//  Description : Per-button press/long/repeat/release FSMs, round-robin
//                arbitration into a small show-ahead event FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module btn_event_ctrl #(
    parameter int N_BTN      = 4,
    parameter int CNT_W      = 16,
    parameter int LONG_CYC   = 50000,
    parameter int REPEAT_CYC = 10000,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [N_BTN-1:0]              btn_lvl,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [$clog2(N_BTN)-1:0]      evt_id,
    output logic [1:0]                    evt_code,
    output logic [$clog2(FIFO_DEPTH):0]   evt_count,
    output logic                          drop_flag,
    input  logic                          clr_drop
);

    localparam int IDW = $clog2(N_BTN);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int CW  = PW + 1;

    localparam logic [1:0] EVT_PRESS   = 2'd0;
    localparam logic [1:0] EVT_LONG    = 2'd1;
    localparam logic [1:0] EVT_REPEAT  = 2'd2;
    localparam logic [1:0] EVT_RELEASE = 2'd3;

    localparam logic [CNT_W-1:0] c_long_m1 = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] c_rep_m1  = (REPEAT_CYC == 0) ? '0 : CNT_W'(REPEAT_CYC - 1);
    localparam logic [CW-1:0]    c_depth   = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_PRESSED = 2'd1,
        ST_REPEAT  = 2'd2
    } btn_state_e;

    btn_state_e         state_q   [N_BTN];
    btn_state_e         state_d   [N_BTN];
    logic [CNT_W-1:0]   cnt_q     [N_BTN];
    logic [CNT_W-1:0]   cnt_d     [N_BTN];
    logic [N_BTN-1:0]   gen_v;
    logic [1:0]         gen_code  [N_BTN];

    logic [N_BTN-1:0]   pend_v_q, pend_v_d;
    logic [1:0]         pend_code_q [N_BTN];
    logic [1:0]         pend_code_d [N_BTN];

    logic [IDW-1:0]     last_grant_q;
    logic [IDW-1:0]     grant_idx;
    logic [IDW-1:0]     cand;
    logic               grant_any;
    logic [N_BTN-1:0]   grant_oh;
    logic               any_drop;

    logic [IDW-1:0]     fifo_id_q   [FIFO_DEPTH];
    logic [1:0]         fifo_code_q [FIFO_DEPTH];
    logic [PW-1:0]      wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]      count_q;
    logic               drop_q, drop_d;
    logic               push, pop;

    // Per-button event FSMs; release always takes precedence over timers.
    always_comb begin
        gen_v = '0;
        for (int i = 0; i < N_BTN; i++) begin
            state_d[i]  = state_q[i];
            cnt_d[i]    = cnt_q[i];
            gen_code[i] = EVT_PRESS;
            case (state_q[i])
                ST_IDLE: begin
                    if (btn_lvl[i]) begin
                        state_d[i] = ST_PRESSED;
                        cnt_d[i]   = '0;
                        gen_v[i]   = 1'b1;
                    end
                end
                ST_PRESSED: begin
                    if (!btn_lvl[i]) begin
                        state_d[i]  = ST_IDLE;
                        cnt_d[i]    = '0;
                        gen_v[i]    = 1'b1;
                        gen_code[i] = EVT_RELEASE;
                    end else if (cnt_q[i] == c_long_m1) begin
                        state_d[i]  = ST_REPEAT;
                        cnt_d[i]    = '0;
                        gen_v[i]    = 1'b1;
                        gen_code[i] = EVT_LONG;
                    end else begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                ST_REPEAT: begin
                    if (!btn_lvl[i]) begin
                        state_d[i]  = ST_IDLE;
                        cnt_d[i]    = '0;
                        gen_v[i]    = 1'b1;
                        gen_code[i] = EVT_RELEASE;
                    end else if ((REPEAT_CYC != 0) && (cnt_q[i] == c_rep_m1)) begin
                        cnt_d[i]    = '0;
                        gen_v[i]    = 1'b1;
                        gen_code[i] = EVT_REPEAT;
                    end else if (cnt_q[i] != {CNT_W{1'b1}}) begin
                        cnt_d[i] = cnt_q[i] + 1'b1;
                    end
                end
                default: begin
                    state_d[i] = ST_IDLE;
                    cnt_d[i]   = '0;
                end
            endcase
        end
    end

    // Round-robin search starting just after the last granted button.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        if (count_q < c_depth) begin
            for (int k = 1; k <= N_BTN; k++) begin
                cand = IDW'((int'(last_grant_q) + k) % N_BTN);
                if (!grant_any && pend_v_q[cand]) begin
                    grant_any = 1'b1;
                    grant_idx = cand;
                end
            end
        end
    end

    always_comb begin
        any_drop = 1'b0;
        for (int i = 0; i < N_BTN; i++) begin
            grant_oh[i]    = grant_any && (grant_idx == IDW'(i));
            pend_v_d[i]    = pend_v_q[i] && !grant_oh[i];
            pend_code_d[i] = pend_code_q[i];
            if (gen_v[i]) begin
                if (!pend_v_q[i] || grant_oh[i]) begin
                    pend_v_d[i]    = 1'b1;
                    pend_code_d[i] = gen_code[i];
                end else begin
                    any_drop = 1'b1;
                end
            end
        end
        drop_d = (drop_q && !clr_drop) || any_drop;
    end

    assign push = grant_any;
    assign pop  = (count_q != '0) && evt_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i]     <= ST_IDLE;
                cnt_q[i]       <= '0;
                pend_code_q[i] <= EVT_PRESS;
            end
            pend_v_q     <= '0;
            last_grant_q <= IDW'(N_BTN - 1);
            drop_q       <= 1'b0;
        end else begin
            for (int i = 0; i < N_BTN; i++) begin
                state_q[i]     <= state_d[i];
                cnt_q[i]       <= cnt_d[i];
                pend_code_q[i] <= pend_code_d[i];
            end
            pend_v_q <= pend_v_d;
            drop_q   <= drop_d;
            if (grant_any) begin
                last_grant_q <= grant_idx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < FIFO_DEPTH; j++) begin
                fifo_id_q[j]   <= '0;
                fifo_code_q[j] <= EVT_PRESS;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                fifo_id_q[wr_ptr_q]   <= grant_idx;
                fifo_code_q[wr_ptr_q] <= pend_code_q[grant_idx];
                wr_ptr_q              <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    assign evt_valid = (count_q != '0);
    assign evt_id    = fifo_id_q[rd_ptr_q];
    assign evt_code  = fifo_code_q[rd_ptr_q];
    assign evt_count = count_q;
    assign drop_flag = drop_q;

endmodule

`default_nettype wire

// File: tb/tb_btn_event_ctrl.sv
// ============================================================================
//  Module      : tb_btn_event_ctrl
//  Description : Scoreboard bench for btn_event_ctrl (4 buttons, short timers).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_btn_event_ctrl;

    localparam logic [1:0] P = 2'd0;
    localparam logic [1:0] L = 2'd1;
    localparam logic [1:0] R = 2'd2;
    localparam logic [1:0] X = 2'd3;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_lvl;
    logic       evt_ready;
    logic       clr_drop;
    logic       evt_valid;
    logic [1:0] evt_id;
    logic [1:0] evt_code;
    logic [2:0] evt_count;
    logic       drop_flag;

    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_q[$];

    btn_event_ctrl #(
        .N_BTN      (4),
        .CNT_W      (16),
        .LONG_CYC   (8),
        .REPEAT_CYC (4),
        .FIFO_DEPTH (4)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .btn_lvl   (btn_lvl),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .evt_code  (evt_code),
        .evt_count (evt_count),
        .drop_flag (drop_flag),
        .clr_drop  (clr_drop)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic expect_evt(input logic [1:0] id, input logic [1:0] code);
        exp_q.push_back({id, code});
    endtask

    // Inputs are final here; a handshake seen now is taken at the next edge.
    task automatic cycle();
        logic [3:0] e;
        if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("evt_unexpected", {28'd0, evt_id, evt_code}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                chk("evt", {28'd0, evt_id, evt_code}, {28'd0, e});
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            cycle();
            n++;
        end
        chk("drain_left", exp_q.size(), 0);
        repeat (4) cycle();
    endtask

    task automatic reset_dut();
        rst       = 1'b1;
        btn_lvl   = '0;
        evt_ready = 1'b1;
        clr_drop  = 1'b0;
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        btn_lvl   = '0;
        evt_ready = 1'b1;
        clr_drop  = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", evt_valid, 0);
        chk("rst_id",    evt_id,    0);
        chk("rst_code",  evt_code,  0);
        chk("rst_count", evt_count, 0);
        chk("rst_drop",  drop_flag, 0);
        rst = 1'b0;

        // Short press: PRESS visible two edges after the rise, then RELEASE.
        btn_lvl[2] = 1'b1;
        expect_evt(2, P);
        cycle();
        chk("t1_lat_k", evt_valid, 0);
        cycle();
        chk("t1_lat_k1", evt_valid, 1);
        cycle();
        btn_lvl[2] = 1'b0;
        expect_evt(2, X);
        drain();
        chk("t1_drop", drop_flag, 0);

        // Long hold: LONG after 8 edges, then REPEAT every 4.
        btn_lvl[1] = 1'b1;
        expect_evt(1, P);
        expect_evt(1, L);
        expect_evt(1, R);
        expect_evt(1, R);
        expect_evt(1, R);
        repeat (21) cycle();
        btn_lvl[1] = 1'b0;
        expect_evt(1, X);
        drain();

        // Simultaneous presses and releases come out in id order.
        reset_dut();
        btn_lvl = 4'b1111;
        for (int i = 0; i < 4; i++) expect_evt(2'(i), P);
        repeat (4) cycle();
        btn_lvl = 4'b0000;
        for (int i = 0; i < 4; i++) expect_evt(2'(i), X);
        drain();
        chk("t3_drop", drop_flag, 0);

        // Back-pressure: fill FIFO, fill slots, then lose events.
        evt_ready  = 1'b0;
        btn_lvl[0] = 1'b1; expect_evt(0, P); cycle();
        btn_lvl[0] = 1'b0; expect_evt(0, X); cycle();
        btn_lvl[1] = 1'b1; expect_evt(1, P); cycle();
        btn_lvl[1] = 1'b0; expect_evt(1, X); cycle();
        btn_lvl[2] = 1'b1; expect_evt(2, P); cycle();
        chk("t4_count_full", evt_count, 4);
        btn_lvl[3] = 1'b1; expect_evt(3, P); cycle();
        btn_lvl[0] = 1'b1; expect_evt(0, P); cycle();
        btn_lvl[1] = 1'b1; expect_evt(1, P); cycle();
        chk("t4_count_sat", evt_count, 4);
        chk("t4_no_drop_yet", drop_flag, 0);
        btn_lvl[0] = 1'b0; cycle();
        chk("t4_drop_set", drop_flag, 1);
        btn_lvl  = 4'b0000;
        clr_drop = 1'b1;
        cycle();
        clr_drop = 1'b0;
        chk("t4_drop_set_wins", drop_flag, 1);
        chk("t4_count_hold", evt_count, 4);
        evt_ready = 1'b1;
        drain();
        chk("t4_drained", evt_count, 0);
        clr_drop = 1'b1;
        cycle();
        clr_drop = 1'b0;
        chk("t4_drop_clr", drop_flag, 0);

        // Release exactly when the LONG timer would expire.
        btn_lvl[3] = 1'b1;
        expect_evt(3, P);
        repeat (8) cycle();
        btn_lvl[3] = 1'b0;
        expect_evt(3, X);
        drain();

        // Asynchronous reset with events queued and one pending.
        evt_ready  = 1'b0;
        btn_lvl[1] = 1'b1; cycle();
        btn_lvl[1] = 1'b0; cycle();
        btn_lvl[2] = 1'b1; cycle();
        btn_lvl[0] = 1'b1; cycle();
        chk("t6_count_pre", evt_count, 3);
        rst = 1'b1;
        #1;
        chk("t6_rst_valid", evt_valid, 0);
        chk("t6_rst_count", evt_count, 0);
        btn_lvl[2] = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        evt_ready = 1'b1;
        expect_evt(0, P);
        cycle();
        cycle();
        btn_lvl[0] = 1'b0;
        expect_evt(0, X);
        drain();
        chk("t6_drop", drop_flag, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
